// File: rtl/chrono_timer_bank.sv
// Bank of NUM_CH independent minute:second counters sharing one prescaler tick.
// Each channel counts up (stopwatch) or down (timer), saturates at its terminal value and pulses expired.
module chrono_timer_bank #(
    parameter int unsigned CLK_FREQ_HZ = 100_000_000,
    parameter int unsigned TICK_HZ     = 1,
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned MAX_MIN     = 99,
    localparam int unsigned CHW        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int unsigned MW         = $clog2(MAX_MIN + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    input  logic [CHW-1:0]    cmd_ch,
    input  logic [2:0]        cmd_op,
    input  logic [MW-1:0]     cmd_min,
    input  logic [5:0]        cmd_sec,
    input  logic [CHW-1:0]    rd_ch,
    output logic [MW-1:0]     rd_min,
    output logic [5:0]        rd_sec,
    output logic              rd_running,
    output logic              rd_down,
    output logic              rd_done,
    output logic [NUM_CH-1:0] expired,
    output logic              tick
);

    localparam int unsigned TICK_DIV = CLK_FREQ_HZ / TICK_HZ;
    localparam int unsigned PW       = $clog2(TICK_DIV);

    localparam logic [PW-1:0] DIV_LAST = PW'(TICK_DIV - 1);
    localparam logic [MW-1:0] MIN_MAX  = MW'(MAX_MIN);
    localparam logic [5:0]    SEC_MAX  = 6'd59;

    localparam logic [2:0] OP_NOP       = 3'd0;
    localparam logic [2:0] OP_LOAD      = 3'd1;
    localparam logic [2:0] OP_START     = 3'd2;
    localparam logic [2:0] OP_STOP      = 3'd3;
    localparam logic [2:0] OP_CLEAR     = 3'd4;
    localparam logic [2:0] OP_MODE_UP   = 3'd5;
    localparam logic [2:0] OP_MODE_DOWN = 3'd6;
    localparam logic [2:0] OP_TOGGLE    = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } ch_state_e;

    logic [PW-1:0]     presc_q, presc_d;
    logic              tick_q, tick_d;
    logic [MW-1:0]     min_q   [NUM_CH];
    logic [MW-1:0]     min_d   [NUM_CH];
    logic [5:0]        sec_q   [NUM_CH];
    logic [5:0]        sec_d   [NUM_CH];
    ch_state_e         state_q [NUM_CH];
    ch_state_e         state_d [NUM_CH];
    logic [NUM_CH-1:0] down_q, down_d;
    logic [NUM_CH-1:0] expired_q, expired_d;

    logic [MW-1:0]     load_min_c;
    logic [5:0]        load_sec_c;

    // START is refused when the channel already sits on its terminal value
    function automatic logic can_start(input logic dn, input logic [MW-1:0] mn, input logic [5:0] sc);
        if (dn) begin
            return !((mn == '0) && (sc == '0));
        end
        return !((mn == MIN_MAX) && (sc == SEC_MAX));
    endfunction

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            presc_q   <= '0;
            tick_q    <= 1'b0;
            down_q    <= '0;
            expired_q <= '0;
            for (int i = 0; i < int'(NUM_CH); i++) begin
                min_q[i]   <= '0;
                sec_q[i]   <= '0;
                state_q[i] <= ST_IDLE;
            end
        end else begin
            presc_q   <= presc_d;
            tick_q    <= tick_d;
            down_q    <= down_d;
            expired_q <= expired_d;
            for (int i = 0; i < int'(NUM_CH); i++) begin
                min_q[i]   <= min_d[i];
                sec_q[i]   <= sec_d[i];
                state_q[i] <= state_d[i];
            end
        end
    end

    assign load_min_c = (cmd_min > MIN_MAX) ? MIN_MAX : cmd_min;
    assign load_sec_c = (cmd_sec > SEC_MAX) ? SEC_MAX : cmd_sec;

    // Next state: prescaler, then per channel a command (which drops a coincident tick) or a tick step
    always_comb begin
        presc_d   = (presc_q == DIV_LAST) ? '0 : PW'(presc_q + 1'b1);
        tick_d    = (presc_q == DIV_LAST);
        down_d    = down_q;
        expired_d = '0;

        for (int i = 0; i < int'(NUM_CH); i++) begin
            min_d[i]   = min_q[i];
            sec_d[i]   = sec_q[i];
            state_d[i] = state_q[i];

            if (cmd_valid && (cmd_op != OP_NOP) && (cmd_ch == CHW'(i))) begin
                case (cmd_op)
                    OP_LOAD: begin
                        min_d[i]   = load_min_c;
                        sec_d[i]   = load_sec_c;
                        state_d[i] = ST_IDLE;
                    end
                    OP_CLEAR: begin
                        min_d[i]   = '0;
                        sec_d[i]   = '0;
                        state_d[i] = ST_IDLE;
                    end
                    OP_START: begin
                        if ((state_q[i] == ST_IDLE) && can_start(down_q[i], min_q[i], sec_q[i])) begin
                            state_d[i] = ST_RUN;
                        end
                    end
                    OP_STOP: begin
                        if (state_q[i] == ST_RUN) begin
                            state_d[i] = ST_IDLE;
                        end
                    end
                    OP_TOGGLE: begin
                        if (state_q[i] == ST_RUN) begin
                            state_d[i] = ST_IDLE;
                        end else if ((state_q[i] == ST_IDLE) && can_start(down_q[i], min_q[i], sec_q[i])) begin
                            state_d[i] = ST_RUN;
                        end
                    end
                    OP_MODE_UP, OP_MODE_DOWN: begin
                        if (state_q[i] != ST_RUN) begin
                            down_d[i]  = (cmd_op == OP_MODE_DOWN);
                            state_d[i] = ST_IDLE;
                        end
                    end
                    default: ;
                endcase
            end else if (tick_q && (state_q[i] == ST_RUN)) begin
                if (!down_q[i]) begin
                    if (sec_q[i] != SEC_MAX) begin
                        sec_d[i] = sec_q[i] + 6'd1;
                        if ((min_q[i] == MIN_MAX) && (sec_q[i] == 6'd58)) begin
                            state_d[i]   = ST_DONE;
                            expired_d[i] = 1'b1;
                        end
                    end else begin
                        sec_d[i] = '0;
                        min_d[i] = min_q[i] + MW'(1);
                    end
                end else begin
                    if (sec_q[i] != '0) begin
                        sec_d[i] = sec_q[i] - 6'd1;
                        if ((min_q[i] == '0) && (sec_q[i] == 6'd1)) begin
                            state_d[i]   = ST_DONE;
                            expired_d[i] = 1'b1;
                        end
                    end else begin
                        sec_d[i] = SEC_MAX;
                        min_d[i] = min_q[i] - MW'(1);
                    end
                end
            end
        end
    end

    // Outputs: registered pulses plus a combinational readout mux
    always_comb begin
        tick       = tick_q;
        expired    = expired_q;
        rd_min     = '0;
        rd_sec     = '0;
        rd_running = 1'b0;
        rd_down    = 1'b0;
        rd_done    = 1'b0;
        if (32'(rd_ch) < NUM_CH) begin
            rd_min     = min_q[rd_ch];
            rd_sec     = sec_q[rd_ch];
            rd_running = (state_q[rd_ch] == ST_RUN);
            rd_down    = down_q[rd_ch];
            rd_done    = (state_q[rd_ch] == ST_DONE);
        end
    end

endmodule
